// File: rtl/controller_pkg.sv
// rtl/controller_pkg.sv - widths, delay-table entry type, parse states and delay helper for controller_integrated
package controller_pkg;
    localparam int DATAWIDTH     = 16;
    localparam int ADDR_VEC_W    = 4;
    localparam int ID_W          = 4;
    localparam int SAMPLE_ADDR_W = 10;
    localparam int DELAY_W       = 14;
    localparam int OBJ_ID_W      = 2;
    localparam int N_OBJ         = 4;
    localparam int SCEN_LEN_W    = 13;
    localparam int NOC_OUT       = 8;
    localparam int LOCAL_ID      = 0;

    // Upper delay bits select the controller, lower bits the tap into the sample buffer.
    typedef struct packed {
        logic [ID_W-1:0]          cid;
        logic [SAMPLE_ADDR_W-1:0] tap;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PARSE = 2'd1,
        ST_DONE  = 2'd2
    } parse_state_t;

    function automatic entry_t eff_delay(input logic [DELAY_W-1:0] elem,
                                         input logic [DELAY_W-1:0] lat1,
                                         input logic [DELAY_W-1:0] lat2);
        logic [DELAY_W+1:0] total;
        total = {2'b00, lat1} + {2'b00, lat2};
        if ({2'b00, elem} <= total)
            return '0;
        return entry_t'(elem - lat1 - lat2);
    endfunction
endpackage

// File: rtl/controller_integrated_sample_buffer.sv
// rtl/controller_integrated_sample_buffer.sv - sample memory, one write port, N read ports, two-cycle read latency
module sample_buffer
    import controller_pkg::*;
#(
    parameter int AW = SAMPLE_ADDR_W,
    parameter int DW = 2*DATAWIDTH,
    parameter int NR = N_OBJ
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [DW-1:0]          wr_data,
    input  logic [NR-1:0][AW-1:0]  rd_addr,
    output logic [NR-1:0][DW-1:0]  rd_data
);
    logic [DW-1:0]         mem [2**AW];
    logic [NR-1:0][AW-1:0] rd_addr_q;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_q <= '0;
            rd_data   <= '0;
        end else begin
            rd_addr_q <= rd_addr;
            for (int k = 0; k < NR; k++)
                rd_data[k] <= mem[rd_addr_q[k]];
        end
    end
endmodule

// File: rtl/controller_integrated.sv
// rtl/controller_integrated.sv - delay-table controller: table load/parse, sample tapping, NoC routing, prefetch
// Optional prefetch bypass streaming: CONTROLLER_PREFETCH_BYPASS_EN
module controller_integrated
    import controller_pkg::*;
#(
    parameter int DATAWIDTH     = 16,
    parameter int ADDR_VEC_W    = 4,
    parameter int ID_W          = 4,
    parameter int SAMPLE_ADDR_W = 10,
    parameter int DELAY_W       = 14,
    parameter int OBJ_ID_W      = 2,
    parameter int N_OBJ         = 4,
    parameter int SCEN_LEN_W    = 13,
    parameter int NOC_OUT       = 8,
    parameter int LOCAL_ID      = 0
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          boot_up,
    input  logic                          input_valid,
    input  logic                          glob_scen_noc_input_valid,
    input  logic                          boot_up_local,
    input  logic                          table_parse,
    input  logic                          boot_up_table_update,
    input  logic                          start,
    input  logic [DELAY_W-1:0]            delay_matrix_element,
    input  logic [OBJ_ID_W-1:0]           obj_id_element,
    input  logic [DELAY_W-1:0]            hardware_latency1,
    input  logic [DELAY_W-1:0]            hardware_latency2,
    input  logic [SCEN_LEN_W-1:0]         scenario_len,
    input  logic [2*DATAWIDTH-1:0]        data_in,
    output logic [SCEN_LEN_W-1:0]         scenario_counter,
    output logic                          scenario_update,
    output logic                          scenario_update_global,
    output logic [SAMPLE_ADDR_W-1:0]      addr,
    output logic                          valid_bit,
    output logic                          prefetch_enable,
    output logic [SAMPLE_ADDR_W+OBJ_ID_W-1:0] tapping_loc_packet,
    output logic                          tapping_loc_valid,
    output logic [ID_W-1:0]               local_controller_id,
    output logic [SAMPLE_ADDR_W-1:0]      from_glob_prefetch_start,
    output logic [SAMPLE_ADDR_W-1:0]      from_glob_prefetch_stop,
    output logic [ADDR_VEC_W-1:0]         from_glob_prefetch_dest,
    output logic [ADDR_VEC_W-1:0]         prefetch_bypass_dest_addr_int,
    output logic [ADDR_VEC_W-1:0]         prefetch_bypass_path_input_addr,
    output logic [SAMPLE_ADDR_W-1:0]      prefetch_bypass_cycles,
    output logic [DELAY_W-1:0]            prefetch_bypass_start_addr,
    output logic [2*DATAWIDTH-1:0]        prefetch_bypass_path_input_data,
    output logic                          prefetch_bypass_valid,
    output logic [ADDR_VEC_W-1:0]         real_bypass_dest_addr_int,
    output logic [ADDR_VEC_W-1:0]         real_bypass_path_input_addr,
    output logic [SAMPLE_ADDR_W+OBJ_ID_W-1:0] real_bypass_tap_loc,
    output logic [2*DATAWIDTH-1:0]        real_bypass_path_input_data,
    output logic                          real_bypass_reqd,
    output logic                          real_bypass_valid,
    output logic                          real_bypass_tap_loc_valid,
    output logic [2*DATAWIDTH-1:0]        shift_reg_out_0,
    output logic [2*DATAWIDTH-1:0]        shift_reg_out_1,
    output logic [2*DATAWIDTH-1:0]        shift_reg_out_2,
    output logic [2*DATAWIDTH-1:0]        shift_reg_out_3,
    output logic [2*DATAWIDTH-1:0]        noc_out_0_final,
    output logic [2*DATAWIDTH-1:0]        noc_out_1_final,
    output logic [2*DATAWIDTH-1:0]        noc_out_2_final,
    output logic [2*DATAWIDTH-1:0]        noc_out_3_final,
    output logic [2*DATAWIDTH-1:0]        noc_out_4_final,
    output logic [2*DATAWIDTH-1:0]        noc_out_5_final,
    output logic [2*DATAWIDTH-1:0]        noc_out_6_final,
    output logic [2*DATAWIDTH-1:0]        noc_out_7_final,
    output logic [NOC_OUT-1:0]            from_noc_output_valid
);
    localparam int SEL_W = $clog2(NOC_OUT);

    entry_t                             active [N_OBJ];
    entry_t                             shadow [N_OBJ];
    entry_t                             new_entry;
    entry_t                             cur;
    parse_state_t                       state;
    logic [OBJ_ID_W-1:0]                obj;
    logic                               running;
    logic                               wrap;
    logic                               copy;
    logic                               in_parse;
    logic                               remote;
    logic                               pf_hit;
    logic [OBJ_ID_W-1:0]                pf_obj;
    logic [SAMPLE_ADDR_W-1:0]           tap_new;
    logic [SAMPLE_ADDR_W-1:0]           tap_old;
    logic [2*DATAWIDTH-1:0]             data_d1;
    logic [N_OBJ-1:0][SAMPLE_ADDR_W-1:0] rd_addr;
    logic [N_OBJ-1:0][2*DATAWIDTH-1:0]  rd_data;
    logic [2*DATAWIDTH-1:0]             tapped [N_OBJ];
    logic [2*DATAWIDTH-1:0]             noc [NOC_OUT];

    assign new_entry = eff_delay(delay_matrix_element, hardware_latency1, hardware_latency2);
    assign wrap      = running && (scenario_counter == scenario_len - SCEN_LEN_W'(1));
    assign copy      = boot_up_table_update || wrap;

    assign scenario_update        = wrap;
    assign scenario_update_global = wrap;

    // A copy lands first; a same-cycle boot write to an entry overrides it.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_OBJ; k++) begin
                active[k] <= '0;
                shadow[k] <= '0;
            end
        end else begin
            if (copy)
                for (int k = 0; k < N_OBJ; k++)
                    active[k] <= shadow[k];
            if (boot_up && input_valid)
                active[obj_id_element] <= new_entry;
            if (glob_scen_noc_input_valid)
                shadow[obj_id_element] <= new_entry;
        end
    end

    // Lowest object whose controller id differs between shadow and active.
    always_comb begin
        pf_hit = 1'b0;
        pf_obj = '0;
        for (int k = N_OBJ-1; k >= 0; k--) begin
            if (shadow[k].cid != active[k].cid) begin
                pf_hit = 1'b1;
                pf_obj = OBJ_ID_W'(k);
            end
        end
    end

    assign tap_new = shadow[pf_obj].tap;
    assign tap_old = active[pf_obj].tap;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            prefetch_enable          <= 1'b0;
            from_glob_prefetch_start <= '0;
            from_glob_prefetch_stop  <= '0;
            from_glob_prefetch_dest  <= '0;
        end else begin
            prefetch_enable <= copy && pf_hit;
            if (copy && pf_hit) begin
                from_glob_prefetch_start <= tap_new;
                from_glob_prefetch_stop  <= tap_old;
                from_glob_prefetch_dest  <= shadow[pf_obj].cid[ADDR_VEC_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            addr             <= '0;
            scenario_counter <= '0;
            running          <= 1'b0;
            data_d1          <= '0;
        end else begin
            data_d1 <= data_in;
            if (start) begin
                addr             <= '0;
                scenario_counter <= '0;
                running          <= 1'b1;
            end else if (running) begin
                addr             <= addr + SAMPLE_ADDR_W'(1);
                scenario_counter <= wrap ? '0 : scenario_counter + SCEN_LEN_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            obj       <= '0;
            valid_bit <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (table_parse && boot_up_local) begin
                    state     <= ST_PARSE;
                    obj       <= '0;
                    valid_bit <= 1'b0;
                end
                ST_PARSE: if (obj == OBJ_ID_W'(N_OBJ-1)) begin
                    state     <= ST_DONE;
                    valid_bit <= 1'b1;
                end else begin
                    obj <= obj + OBJ_ID_W'(1);
                end
                ST_DONE: if (!boot_up_local)
                    state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cur      = active[obj];
    assign in_parse = (state == ST_PARSE);
    assign remote   = in_parse && (cur.cid != ID_W'(LOCAL_ID));

    assign tapping_loc_valid           = in_parse;
    assign tapping_loc_packet          = in_parse ? {obj, cur.tap} : '0;
    assign local_controller_id         = in_parse ? cur.cid : '0;
    assign real_bypass_reqd            = remote;
    assign real_bypass_valid           = remote;
    assign real_bypass_tap_loc_valid   = remote;
    assign real_bypass_tap_loc         = remote ? {obj, cur.tap} : '0;
    assign real_bypass_dest_addr_int   = remote ? cur.cid[ADDR_VEC_W-1:0] : '0;
    assign real_bypass_path_input_addr = remote ? cur.cid[ADDR_VEC_W-1:0] : '0;
    assign real_bypass_path_input_data = remote ? data_in : '0;

    // Read two ahead so the registered data lines up with the current write pointer.
    always_comb begin
        for (int k = 0; k < N_OBJ; k++)
            rd_addr[k] = addr + SAMPLE_ADDR_W'(2) - active[k].tap;
    end

    sample_buffer #(
        .AW (SAMPLE_ADDR_W),
        .DW (2*DATAWIDTH),
        .NR (N_OBJ)
    ) u_sample_buffer (
        .clk     (CLK),
        .rst     (reset),
        .wr_en   (running),
        .wr_addr (addr),
        .wr_data (data_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Taps shorter than the memory latency come straight from the input pipeline.
    always_comb begin
        for (int k = 0; k < N_OBJ; k++) begin
            if (!running)
                tapped[k] = '0;
            else if (active[k].tap == SAMPLE_ADDR_W'(0))
                tapped[k] = data_in;
            else if (active[k].tap == SAMPLE_ADDR_W'(1))
                tapped[k] = data_d1;
            else
                tapped[k] = rd_data[k];
        end
    end

    assign shift_reg_out_0 = tapped[0];
    assign shift_reg_out_1 = tapped[1];
    assign shift_reg_out_2 = tapped[2];
    assign shift_reg_out_3 = tapped[3];

    always_comb begin
        from_noc_output_valid = '0;
        for (int j = 0; j < NOC_OUT; j++)
            noc[j] = '0;
        for (int j = 0; j < NOC_OUT; j++) begin
            for (int k = N_OBJ-1; k >= 0; k--) begin
                if (active[k].cid[SEL_W-1:0] == SEL_W'(j)) begin
                    noc[j]                   = tapped[k];
                    from_noc_output_valid[j] = 1'b1;
                end
            end
        end
        if (reset)
            from_noc_output_valid = '0;
    end

    assign noc_out_0_final = noc[0];
    assign noc_out_1_final = noc[1];
    assign noc_out_2_final = noc[2];
    assign noc_out_3_final = noc[3];
    assign noc_out_4_final = noc[4];
    assign noc_out_5_final = noc[5];
    assign noc_out_6_final = noc[6];
    assign noc_out_7_final = noc[7];

`ifdef CONTROLLER_PREFETCH_BYPASS_EN
    logic [SAMPLE_ADDR_W-1:0] pb_left;
    logic [SAMPLE_ADDR_W-1:0] tap_span;
    logic [ADDR_VEC_W-1:0]    pb_dest;

    assign tap_span = (tap_new >= tap_old) ? tap_new - tap_old : tap_old - tap_new;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pb_left                    <= '0;
            pb_dest                    <= '0;
            prefetch_bypass_cycles     <= '0;
            prefetch_bypass_start_addr <= '0;
        end else if (copy && pf_hit) begin
            pb_left                    <= tap_span;
            pb_dest                    <= shadow[pf_obj].cid[ADDR_VEC_W-1:0];
            prefetch_bypass_cycles     <= tap_span;
            prefetch_bypass_start_addr <= shadow[pf_obj];
        end else if (pb_left != '0) begin
            pb_left <= pb_left - SAMPLE_ADDR_W'(1);
        end
    end

    assign prefetch_bypass_valid           = (pb_left != '0);
    assign prefetch_bypass_dest_addr_int   = pb_dest;
    assign prefetch_bypass_path_input_addr = pb_dest;
    assign prefetch_bypass_path_input_data = prefetch_bypass_valid ? data_in : '0;
`else
    assign prefetch_bypass_valid           = 1'b0;
    assign prefetch_bypass_dest_addr_int   = '0;
    assign prefetch_bypass_path_input_addr = '0;
    assign prefetch_bypass_path_input_data = '0;
    assign prefetch_bypass_cycles          = '0;
    assign prefetch_bypass_start_addr      = '0;
`endif
endmodule

// File: tb/tb_controller_integrated.sv
// tb/tb_controller_integrated.sv - directed self-checking bench for controller_integrated
module tb_controller_integrated;
    localparam logic [31:0] BASE = 32'h00fffffe;

    logic        CLK = 1'b0;
    logic        reset;
    logic        boot_up, input_valid, glob_scen_noc_input_valid;
    logic        boot_up_local, table_parse, boot_up_table_update, start;
    logic [13:0] delay_matrix_element, hardware_latency1, hardware_latency2;
    logic [1:0]  obj_id_element;
    logic [12:0] scenario_len;
    logic [31:0] data_in;
    logic [12:0] scenario_counter;
    logic        scenario_update, scenario_update_global;
    logic [9:0]  addr;
    logic        valid_bit, prefetch_enable;
    logic [11:0] tapping_loc_packet;
    logic        tapping_loc_valid;
    logic [3:0]  local_controller_id;
    logic [9:0]  from_glob_prefetch_start, from_glob_prefetch_stop;
    logic [3:0]  from_glob_prefetch_dest;
    logic [3:0]  pb_dest, pb_path;
    logic [9:0]  pb_cycles;
    logic [13:0] pb_start;
    logic [31:0] pb_data;
    logic        pb_valid;
    logic [3:0]  rb_dest, rb_path;
    logic [11:0] rb_tap_loc;
    logic [31:0] rb_data;
    logic        rb_reqd, rb_valid, rb_tap_loc_valid;
    logic [31:0] sro0, sro1, sro2, sro3;
    logic [31:0] noc0, noc1, noc2, noc3, noc4, noc5, noc6, noc7;
    logic [7:0]  from_noc_output_valid;

    int n_checks = 0;
    int n_errors = 0;

    controller_integrated dut (
        .CLK(CLK), .reset(reset), .boot_up(boot_up), .input_valid(input_valid),
        .glob_scen_noc_input_valid(glob_scen_noc_input_valid), .boot_up_local(boot_up_local),
        .table_parse(table_parse), .boot_up_table_update(boot_up_table_update), .start(start),
        .delay_matrix_element(delay_matrix_element), .obj_id_element(obj_id_element),
        .hardware_latency1(hardware_latency1), .hardware_latency2(hardware_latency2),
        .scenario_len(scenario_len), .data_in(data_in), .scenario_counter(scenario_counter),
        .scenario_update(scenario_update), .scenario_update_global(scenario_update_global),
        .addr(addr), .valid_bit(valid_bit), .prefetch_enable(prefetch_enable),
        .tapping_loc_packet(tapping_loc_packet), .tapping_loc_valid(tapping_loc_valid),
        .local_controller_id(local_controller_id),
        .from_glob_prefetch_start(from_glob_prefetch_start), .from_glob_prefetch_stop(from_glob_prefetch_stop),
        .from_glob_prefetch_dest(from_glob_prefetch_dest),
        .prefetch_bypass_dest_addr_int(pb_dest), .prefetch_bypass_path_input_addr(pb_path),
        .prefetch_bypass_cycles(pb_cycles), .prefetch_bypass_start_addr(pb_start),
        .prefetch_bypass_path_input_data(pb_data), .prefetch_bypass_valid(pb_valid),
        .real_bypass_dest_addr_int(rb_dest), .real_bypass_path_input_addr(rb_path),
        .real_bypass_tap_loc(rb_tap_loc), .real_bypass_path_input_data(rb_data),
        .real_bypass_reqd(rb_reqd), .real_bypass_valid(rb_valid), .real_bypass_tap_loc_valid(rb_tap_loc_valid),
        .shift_reg_out_0(sro0), .shift_reg_out_1(sro1), .shift_reg_out_2(sro2), .shift_reg_out_3(sro3),
        .noc_out_0_final(noc0), .noc_out_1_final(noc1), .noc_out_2_final(noc2), .noc_out_3_final(noc3),
        .noc_out_4_final(noc4), .noc_out_5_final(noc5), .noc_out_6_final(noc6), .noc_out_7_final(noc7),
        .from_noc_output_valid(from_noc_output_valid)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_entry(input int o, input int e, input int l1, input int l2,
                               input logic iv, input logic gv);
        obj_id_element            = 2'(o);
        delay_matrix_element      = 14'(e);
        hardware_latency1         = 14'(l1);
        hardware_latency2         = 14'(l2);
        input_valid               = iv;
        glob_scen_noc_input_valid = gv;
        tick();
        input_valid               = 1'b0;
        glob_scen_noc_input_valid = 1'b0;
    endtask

    int exp_cid [4] = '{9, 9, 11, 0};
    int exp_tap [4] = '{794, 784, 736, 0};

    initial begin
        int  c;
        bit  hit;
        reset = 1'b1;
        boot_up = 0; input_valid = 0; glob_scen_noc_input_valid = 0;
        boot_up_local = 0; table_parse = 0; boot_up_table_update = 0; start = 0;
        delay_matrix_element = 0; obj_id_element = 0; hardware_latency1 = 0; hardware_latency2 = 0;
        scenario_len = 0; data_in = 0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_counter", 64'(scenario_counter), 64'd0);
        chk("rst_noc_valid", 64'(from_noc_output_valid), 64'd0);
        chk("rst_tap_valid", 64'(tapping_loc_valid), 64'd0);
        chk("rst_valid_bit", 64'(valid_bit), 64'd0);
        chk("rst_sro0", 64'(sro0), 64'd0);
        tick();
        reset = 1'b0;

        // Load active and shadow together; obj2 exercises subtraction, obj3 saturation.
        boot_up = 1'b1;
        write_entry(1, 10000, 0, 0, 1'b1, 1'b1);
        write_entry(0, 10010, 0, 0, 1'b1, 1'b1);
        write_entry(2, 12010, 6, 4, 1'b1, 1'b1);
        write_entry(3, 5, 4, 3, 1'b1, 1'b1);
        boot_up = 1'b0;
        hardware_latency1 = 0;
        hardware_latency2 = 0;

        boot_up_local = 1'b1;
        table_parse   = 1'b1;
        data_in       = 32'h1234_5678;
        tick();
        table_parse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk($sformatf("parse%0d_packet", i), 64'(tapping_loc_packet), 64'((i << 10) | exp_tap[i]));
            chk($sformatf("parse%0d_cid", i), 64'(local_controller_id), 64'(exp_cid[i]));
            chk($sformatf("parse%0d_valid", i), 64'(tapping_loc_valid), 64'd1);
            chk($sformatf("parse%0d_reqd", i), 64'(rb_reqd), 64'(exp_cid[i] != 0));
            chk($sformatf("parse%0d_rb_dest", i), 64'(rb_dest), (exp_cid[i] != 0) ? 64'(exp_cid[i]) : 64'd0);
            chk($sformatf("parse%0d_rb_data", i), 64'(rb_data), (exp_cid[i] != 0) ? 64'h1234_5678 : 64'd0);
            tick();
        end
        @(negedge CLK);
        chk("done_valid_bit", 64'(valid_bit), 64'd1);
        chk("done_tap_valid", 64'(tapping_loc_valid), 64'd0);
        boot_up_local = 1'b0;
        tick();

        // Shadow update that keeps every cid: no prefetch.
        boot_up = 1'b1;
        write_entry(0, 10009, 0, 0, 1'b0, 1'b1);
        boot_up = 1'b0;
        boot_up_table_update = 1'b1;
        tick();
        boot_up_table_update = 1'b0;
        @(negedge CLK);
        chk("update_no_prefetch", 64'(prefetch_enable), 64'd0);

        boot_up_local = 1'b1;
        table_parse   = 1'b1;
        tick();
        table_parse = 1'b0;
        @(negedge CLK);
        chk("reparse_tap0", 64'(tapping_loc_packet), 64'd793);
        chk("reparse_cid0", 64'(local_controller_id), 64'd9);
        repeat (4) tick();

        // Shadow obj3 moves to controller 5; takes effect at the scenario wrap.
        boot_up = 1'b1;
        write_entry(3, 5220, 0, 0, 1'b0, 1'b1);
        boot_up = 1'b0;
        scenario_len = 13'h1ff0;

        start   = 1'b1;
        data_in = BASE;
        tick();
        start = 1'b0;
        for (c = 1; c <= 1000; c++) begin
            data_in = BASE + 32'(c);
            if (c < 1000) tick();
        end
        c = 1000;
        @(negedge CLK);
        chk("run_addr", 64'(addr), 64'd999);
        chk("run_counter", 64'(scenario_counter), 64'd999);
        chk("sro1_lag784", 64'(sro1), 64'(data_in - 32'd784));
        chk("sro0_lag793", 64'(sro0), 64'(data_in - 32'd793));
        chk("sro2_lag736", 64'(sro2), 64'(data_in - 32'd736));
        chk("sro3_tap0", 64'(sro3), 64'(data_in));
        chk("noc1_mirror", 64'(noc1), 64'(data_in - 32'd793));
        chk("noc3_obj2", 64'(noc3), 64'(data_in - 32'd736));
        chk("noc0_obj3", 64'(noc0), 64'(data_in));
        chk("noc2_empty", 64'(noc2), 64'd0);
        chk("noc_valid", 64'(from_noc_output_valid), 64'h0b);
        chk("no_update_yet", 64'(scenario_update), 64'd0);

        hit = 1'b0;
        while (c < 10000 && !hit) begin
            tick();
            c++;
            data_in = BASE + 32'(c);
            @(negedge CLK);
            if (scenario_counter == 13'd8174)
                chk("pre_wrap_update", 64'(scenario_update), 64'd0);
            if (scenario_counter == 13'd8175) begin
                hit = 1'b1;
                chk("wrap_cycle", 64'(c), 64'd8176);
                chk("wrap_addr", 64'(addr), 64'd1007);
                chk("wrap_update", 64'(scenario_update), 64'd1);
                chk("wrap_update_global", 64'(scenario_update_global), 64'd1);
                chk("wrap_no_prefetch_yet", 64'(prefetch_enable), 64'd0);
            end
        end
        chk("wrap_reached", 64'(hit), 64'd1);
        tick();
        @(negedge CLK);
        chk("post_wrap_counter", 64'(scenario_counter), 64'd0);
        chk("post_wrap_update", 64'(scenario_update), 64'd0);
        chk("prefetch_pulse", 64'(prefetch_enable), 64'd1);
        chk("prefetch_start", 64'(from_glob_prefetch_start), 64'd100);
        chk("prefetch_stop", 64'(from_glob_prefetch_stop), 64'd0);
        chk("prefetch_dest", 64'(from_glob_prefetch_dest), 64'd5);
        chk("pb_tied_off", 64'(pb_valid), 64'd0);
        tick();
        @(negedge CLK);
        chk("prefetch_one_cycle", 64'(prefetch_enable), 64'd0);
        chk("pre_reset_valid_bit", 64'(valid_bit), 64'd1);

        @(posedge CLK);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid_bit", 64'(valid_bit), 64'd0);
        chk("mid_rst_counter", 64'(scenario_counter), 64'd0);
        chk("mid_rst_addr", 64'(addr), 64'd0);
        chk("mid_rst_sro1", 64'(sro1), 64'd0);
        chk("mid_rst_noc1", 64'(noc1), 64'd0);
        chk("mid_rst_noc_valid", 64'(from_noc_output_valid), 64'd0);
        chk("mid_rst_prefetch_start", 64'(from_glob_prefetch_start), 64'd0);
        chk("mid_rst_tap_valid", 64'(tapping_loc_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/controller_integrated.md
CONTROLLER_INTEGRATED -- requirements
Module: controller_integrated

Interface
REQ-001 Parameters SHALL be: DATAWIDTH 16 (I/Q half-width); ADDR_VEC_W 4 (destination address width); ID_W 4 (controller id width); SAMPLE_ADDR_W 10 (sample buffer address width); DELAY_W 14 (delay width); OBJ_ID_W 2 (object index width); N_OBJ 4 (objects); SCEN_LEN_W 13 (scenario counter width); NOC_OUT 8 (NoC ports); LOCAL_ID 0 (this controller's id).
REQ-002 CLK  in  1  sole clock; reset  in  1  asynchronous, active-high reset.
REQ-003 boot_up, input_valid  in  1  initial table load phase and write strobe.
REQ-004 glob_scen_noc_input_valid  in  1  shadow-table write strobe.
REQ-005 boot_up_local, table_parse  in  1  parse enable and parse request.
REQ-006 boot_up_table_update  in  1  copies the shadow table to the active table.
REQ-007 start  in  1  scenario start pulse.
REQ-008 delay_matrix_element  in  DELAY_W, obj_id_element  in  OBJ_ID_W  table entry and its index.
REQ-009 hardware_latency1, hardware_latency2  in  DELAY_W  latencies subtracted from every delay.
REQ-010 scenario_len  in  SCEN_LEN_W; data_in  in  2*DATAWIDTH  sample stream.
REQ-011 scenario_counter  out  SCEN_LEN_W; scenario_update, scenario_update_global  out  1  (identical).
REQ-012 addr  out  SAMPLE_ADDR_W  sample write pointer; valid_bit, prefetch_enable  out  1.
REQ-013 tapping_loc_packet  out  SAMPLE_ADDR_W+OBJ_ID_W; tapping_loc_valid  out  1; local_controller_id  out  ID_W.
REQ-014 from_glob_prefetch_start, from_glob_prefetch_stop  out  SAMPLE_ADDR_W; from_glob_prefetch_dest  out  ADDR_VEC_W.
REQ-015 prefetch_bypass_{dest_addr_int, path_input_addr}  out  ADDR_VEC_W; prefetch_bypass_cycles  out  SAMPLE_ADDR_W; prefetch_bypass_start_addr  out  DELAY_W; prefetch_bypass_path_input_data  out  2*DATAWIDTH; prefetch_bypass_valid  out  1.
REQ-016 real_bypass_{dest_addr_int, path_input_addr}  out  ADDR_VEC_W; real_bypass_tap_loc  out  SAMPLE_ADDR_W+OBJ_ID_W; real_bypass_path_input_data  out  2*DATAWIDTH; real_bypass_{reqd, valid, tap_loc_valid}  out  1.
REQ-017 shift_reg_out_0..3  out  2*DATAWIDTH  per-object tapped samples; noc_out_0..7_final  out  2*DATAWIDTH; from_noc_output_valid  out  NOC_OUT.

Function
REQ-018 Effective delay SHALL be d = delay_matrix_element - hardware_latency1 - hardware_latency2, saturating at 0; cid = d[DELAY_W-1:SAMPLE_ADDR_W]; tap = d[SAMPLE_ADDR_W-1:0].
REQ-019 While boot_up=1, input_valid SHALL write d into active-table entry obj_id_element on the next edge; glob_scen_noc_input_valid SHALL write the shadow table; when both strobes fire in one cycle, both writes SHALL occur.
REQ-020 boot_up_table_update=1 SHALL copy shadow to active in one cycle; the same copy SHALL occur at each scenario wrap.
REQ-021 The parse FSM SHALL have states IDLE, PARSE, DONE: IDLE->PARSE when table_parse and boot_up_local are both 1; PARSE emits objects 0..N_OBJ-1, one per cycle, then goes to DONE; DONE->IDLE when boot_up_local=0.
REQ-022 In PARSE, tapping_loc_valid=1, tapping_loc_packet={obj,tap}, local_controller_id=cid; if cid!=LOCAL_ID, real_bypass_reqd, real_bypass_tap_loc_valid and real_bypass_valid SHALL be 1, real_bypass_tap_loc={obj,tap}, dest/path_input_addr=cid[ADDR_VEC_W-1:0], real_bypass_path_input_data=data_in. valid_bit SHALL set on entry to DONE.
REQ-023 start SHALL clear addr and scenario_counter, then both increment every cycle; addr wraps modulo 2^SAMPLE_ADDR_W; at scenario_len-1 the counter returns to 0 and scenario_update pulses for one cycle.
REQ-024 Each cycle after start, data_in SHALL be written at addr; shift_reg_out_k SHALL equal the sample written tap_k cycles earlier (two-cycle read latency), and 0 before start.
REQ-025 noc_out_j_final SHALL carry shift_reg_out_k of the lowest k with cid_k[2:0]=j, with from_noc_output_valid[j]=1; otherwise 0 and valid 0.
REQ-026 When a shadow-to-active copy changes an object's cid, prefetch_enable SHALL pulse for one cycle with from_glob_prefetch_start=new tap, from_glob_prefetch_stop=old tap, and from_glob_prefetch_dest=new cid[ADDR_VEC_W-1:0].

Reset
REQ-027 While reset=1, all tables, counters, addr and FSM SHALL clear to 0/IDLE, and every output SHALL be 0.

Configuration
REQ-028 With CONTROLLER_PREFETCH_BYPASS_EN defined, during a prefetch the prefetch_bypass_* outputs SHALL stream data_in to the new cid for |new tap - old tap| cycles: cycles=that count, start_addr=new d, valid=1 during streaming. Without the macro, all prefetch_bypass_* outputs SHALL be tied to 0.

Structure
REQ-029 Package controller_pkg SHALL hold width constants, the table-entry struct and the FSM state enum.
REQ-030 Sub-module sample_buffer SHALL be a 2^SAMPLE_ADDR_W x 2*DATAWIDTH memory with one write port and N_OBJ read ports.

Verification
REQ-031 hardware_latency1=hardware_latency2=0, boot load obj1=10000, obj0=10010, obj2=12000 -> parse emits cid/tap 9/794 (obj0), 9/784 (obj1), 11/736 (obj2), 0/0 (obj3).
REQ-032 Same table, with LOCAL_ID=0 -> real_bypass_reqd=1 for obj0-2, 0 for obj3.
REQ-033 Shadow obj0=10009, then boot_up_table_update -> active tap0=793, no prefetch_enable pulse.
REQ-034 start with data_in incrementing from 0x00fffffe -> shift_reg_out_1 lags data_in by 784 cycles; noc_out_1_final mirrors shift_reg_out_0.
REQ-035 scenario_len=0x1ff0 -> scenario_update pulses at counter 8175, then the shadow copy occurs.
REQ-036 Assert reset mid-scenario -> all outputs are 0 within the same cycle.
